aes_ctr_stream: RTL and testbench

CTR-mode wrapper for the unrolled AES-128 pipeline core (`aes`).
- Upstream: accepts 128-bit plaintext blocks over a valid/ready handshake, issues one counter block per accepted plaintext onto the core's `data_0..3`, and increments the counter.
- Downstream: catches the keystream on the core's `out_0..3` exactly `CORE_LAT` cycles later, XORs it with the matching plaintext, and buffers the ciphertext behind a valid/ready port.
- The core cannot stall, so this block turns its fixed-latency stream into a back-pressurable one.

---
 rtl/aes_ctr_stream.sv | 179 +++++++++++++++++
 tb/tb_aes_ctr_stream.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: CTR-mode wrapper around a fixed-latency, non-stallable AES-128
// pipeline core. Accepted plaintext blocks each launch one counter block into
// the core; the keystream that emerges CORE_LAT cycles later is XORed with the
// parked plaintext and buffered behind a back-pressurable ciphertext port.
// Only ctr[31:0] increments; the upper 96 bits stay fixed after start.
module aes_ctr_stream #(
  parameter int CORE_LAT = 20,
  parameter int DEPTH    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] iv_0,
  input  logic [31:0] iv_1,
  input  logic [31:0] iv_2,
  input  logic [31:0] iv_3,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [31:0] pt_0,
  input  logic [31:0] pt_1,
  input  logic [31:0] pt_2,
  input  logic [31:0] pt_3,
  output logic [31:0] core_data_0,
  output logic [31:0] core_data_1,
  output logic [31:0] core_data_2,
  output logic [31:0] core_data_3,
  input  logic [31:0] core_out_0,
  input  logic [31:0] core_out_1,
  input  logic [31:0] core_out_2,
  input  logic [31:0] core_out_3,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic [31:0] ct_0,
  output logic [31:0] ct_1,
  output logic [31:0] ct_2,
  output logic [31:0] ct_3,
  output logic        busy
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              OW       = AW + 1;
  localparam logic [OW-1:0]   OCC_MAX  = OW'(DEPTH);

  // Counter, occupancy and in-flight tracking
  logic [127:0]         r_ctr;
  logic [OW-1:0]        r_occ;
  logic [CORE_LAT-1:0]  r_vld_dly;

  // Plaintext FIFO: occupancy bounds its fill, so no full/empty flags needed
  logic [127:0]         r_pt_mem [DEPTH];
  logic [AW-1:0]        r_pt_wr;
  logic [AW-1:0]        r_pt_rd;

  // Ciphertext FIFO: extra pointer bit distinguishes empty from full
  logic [127:0]         r_ct_mem [DEPTH];
  logic [AW:0]          r_ct_wr;
  logic [AW:0]          r_ct_rd;

  logic [127:0]         w_iv;
  logic [127:0]         w_pt;
  logic [127:0]         w_ks;
  logic [127:0]         w_pt_head;
  logic [127:0]         w_ct_head;
  logic [127:0]         w_ct_blk;
  logic                 w_accept;
  logic                 w_ks_vld;
  logic                 w_ct_empty;
  logic                 w_ct_pop;
  logic                 w_idle;
  logic [OW-1:0]        w_occ_nxt;

  assign w_iv = {iv_0, iv_1, iv_2, iv_3};
  assign w_pt = {pt_0, pt_1, pt_2, pt_3};
  assign w_ks = {core_out_0, core_out_1, core_out_2, core_out_3};

  // The core sees the live counter; it is sampled by the core on accept cycles.
  assign {core_data_0, core_data_1, core_data_2, core_data_3} = r_ctr;

  // Back-pressure depends only on registered occupancy plus start/reset, never
  // on ct_ready, so a downstream pop frees a slot one cycle later.
  assign w_idle   = (r_occ == '0);
  assign pt_ready = rst_n & ~start & (r_occ < OCC_MAX);
  assign w_accept = pt_valid & pt_ready;

  // The tail of the delay line marks the cycle the core emits a wanted keystream.
  assign w_ks_vld = r_vld_dly[CORE_LAT-1];

  assign w_pt_head  = r_pt_mem[r_pt_rd];
  assign w_ct_empty = (r_ct_wr == r_ct_rd);
  assign w_ct_head  = r_ct_mem[r_ct_rd[AW-1:0]];
  assign ct_valid   = ~w_ct_empty;
  assign w_ct_pop   = ct_valid & ct_ready;
  assign w_ct_blk   = ct_valid ? w_ct_head : '0;
  assign {ct_0, ct_1, ct_2, ct_3} = w_ct_blk;

  assign busy = ~w_idle;

  // Next occupancy: +1 on accept, -1 on ciphertext pop, hold when both or neither.
  always_comb begin
    // NOTE: default assignment first so every path drives w_occ_nxt and no latch is inferred.
    w_occ_nxt = r_occ;
    case ({w_accept, w_ct_pop})
      2'b10:   w_occ_nxt = r_occ + OW'(1);
      2'b01:   w_occ_nxt = r_occ - OW'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Counter: low word steps per accepted block; start reloads only when idle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_ctr <= '0;
    end else if (w_accept) begin
      r_ctr[31:0] <= r_ctr[31:0] + 32'd1;
    end else if (start && w_idle) begin
      r_ctr <= w_iv;
    end
  end

  // Occupancy register: blocks accepted and not yet handed downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  // Delay line tracking which core output cycles carry a wanted keystream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_dly <= '0;
    end else begin
      r_vld_dly[0] <= w_accept;
      for (int i = 1; i < CORE_LAT; i++) begin
        r_vld_dly[i] <= r_vld_dly[i-1];
      end
    end
  end

  // Plaintext FIFO storage: written on accept.
  always_ff @(posedge clk) begin
    // NOTE: FIFO storage is not reset; the reset pointers alone define which entries are valid.
    if (w_accept) begin
      r_pt_mem[r_pt_wr] <= w_pt;
    end
  end

  // Plaintext FIFO pointers: push on accept, pop when the matching keystream arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pt_wr <= '0;
      r_pt_rd <= '0;
    end else begin
      if (w_accept) r_pt_wr <= r_pt_wr + AW'(1);
      if (w_ks_vld) r_pt_rd <= r_pt_rd + AW'(1);
    end
  end

  // Ciphertext FIFO storage: keystream XOR parked plaintext.
  always_ff @(posedge clk) begin
    if (w_ks_vld) begin
      r_ct_mem[r_ct_wr[AW-1:0]] <= w_pt_head ^ w_ks;
    end
  end

  // Ciphertext FIFO pointers: push and pop may both happen in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ct_wr <= '0;
      r_ct_rd <= '0;
    end else begin
      if (w_ks_vld) r_ct_wr <= r_ct_wr + OW'(1);
      if (w_ct_pop) r_ct_rd <= r_ct_rd + OW'(1);
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream: drives aes_ctr_stream against a stand-in for the AES core.
// The stand-in is a CORE_LAT-deep pipeline that returns the published AES-128
// keystream for the four F.5.1 counter blocks and a fixed counter-dependent
// mixing for all other counters. A negedge monitor keeps an independent counter
// model and a scoreboard of expected ciphertext.
module tb_aes_ctr_stream;

  localparam int CORE_LAT = 20;
  localparam int DEPTH    = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] iv_0, iv_1, iv_2, iv_3;
  logic        pt_valid;
  logic        pt_ready;
  logic [31:0] pt_0, pt_1, pt_2, pt_3;
  logic [31:0] core_data_0, core_data_1, core_data_2, core_data_3;
  logic [31:0] core_out_0, core_out_1, core_out_2, core_out_3;
  logic        ct_valid;
  logic        ct_ready;
  logic [31:0] ct_0, ct_1, ct_2, ct_3;
  logic        busy;

  logic [127:0] iv_blk;
  logic [127:0] pt_blk;
  logic [127:0] core_blk;
  logic [127:0] ct_blk;

  assign {iv_0, iv_1, iv_2, iv_3} = iv_blk;
  assign {pt_0, pt_1, pt_2, pt_3} = pt_blk;
  assign core_blk = {core_data_0, core_data_1, core_data_2, core_data_3};
  assign ct_blk   = {ct_0, ct_1, ct_2, ct_3};

  aes_ctr_stream #(.CORE_LAT(CORE_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .iv_0(iv_0), .iv_1(iv_1), .iv_2(iv_2), .iv_3(iv_3),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_0(pt_0), .pt_1(pt_1), .pt_2(pt_2), .pt_3(pt_3),
    .core_data_0(core_data_0), .core_data_1(core_data_1),
    .core_data_2(core_data_2), .core_data_3(core_data_3),
    .core_out_0(core_out_0), .core_out_1(core_out_1),
    .core_out_2(core_out_2), .core_out_3(core_out_3),
    .ct_valid(ct_valid), .ct_ready(ct_ready),
    .ct_0(ct_0), .ct_1(ct_1), .ct_2(ct_2), .ct_3(ct_3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Keystream of the core stand-in.
  function automatic logic [127:0] ks_of(input logic [127:0] c);
    case (c)
      128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff: ks_of = 128'hec8cdf73_98607cb0_f2d21675_ea9ea1e4;
      128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdff00: ks_of = 128'h362b7c3c_67735163_18a077d7_fc5073ae;
      128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdff01: ks_of = 128'h6a2cc378_7889374f_beb4c81b_17ba6c44;
      128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdff02: ks_of = 128'he89c399f_f0f198c6_d40a31db_156cabfe;
      default: ks_of = {c[95:0], c[127:96]} ^ 128'h3c6ef372_a54ff53a_510e527f_9b05688c;
    endcase
  endfunction

  // Core stand-in: fixed-latency pipeline from core_data to core_out.
  logic [127:0] core_pipe [CORE_LAT];
  always @(posedge clk) begin
    core_pipe[0] <= ks_of(core_blk);
    for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign {core_out_0, core_out_1, core_out_2, core_out_3} = core_pipe[CORE_LAT-1];

  // Scoreboard and reference counter.
  logic [127:0] sb [$];
  logic [127:0] ct_log [$];
  logic [127:0] m_ctr = '0;
  int           n_acc = 0;
  int           n_pop = 0;

  always @(negedge clk) begin
    logic [127:0] exp_ct;
    if (!rst_n) begin
      sb.delete();
      m_ctr = '0;
      check("pt_ready_in_reset", 128'(pt_ready), 128'(0));
    end else begin
      check("core_data", core_blk, m_ctr);
      check("pt_ready", 128'(pt_ready), 128'(!start && (sb.size() < DEPTH)));
      check("busy", 128'(busy), 128'(sb.size() != 0));
      if (!ct_valid) check("ct_zero_when_invalid", ct_blk, 128'(0));
      if (ct_valid && ct_ready) begin
        if (sb.size() == 0) begin
          check("ct_unexpected", 128'(ct_valid), 128'(0));
        end else begin
          exp_ct = sb.pop_front();
          check("ct_data", ct_blk, exp_ct);
          ct_log.push_back(ct_blk);
          n_pop++;
        end
      end
      if (pt_valid && pt_ready) begin
        sb.push_back(pt_blk ^ ks_of(m_ctr));
        m_ctr[31:0] = m_ctr[31:0] + 32'd1;
        n_acc++;
      end else if (start && sb.size() == 0) begin
        m_ctr = iv_blk;
      end
    end
  end

  function automatic logic [127:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one block until accepted; returns aligned at posedge+1 after accept.
  task automatic send(input logic [127:0] blk, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    pt_valid = 1'b1;
    pt_blk = blk;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pt_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    pt_valid = 1'b0;
    check("send_accepted", 128'(ok), 128'(1));
  endtask

  task automatic do_start(input logic [127:0] iv);
    start = 1'b1;
    iv_blk = iv;
    @(negedge clk);
    check("pt_ready_during_start", 128'(pt_ready), 128'(0));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check(tag, 128'(sb.size()), 128'(0));
  endtask

  logic [127:0] f51_pt [4] = '{
    128'h6bc1bee2_2e409f96_e93d7e11_7393172a, 128'hae2d8a57_1e03ac9c_9eb76fac_45af8e51,
    128'h30c81c46_a35ce411_e5fbc119_1a0a52ef, 128'hf69f2445_df4f9b17_ad2b417b_e66c3710};
  logic [127:0] f51_ct [4] = '{
    128'h874d6191_b620e326_1bef6864_990db6ce, 128'h9806f66b_7970fdff_8617187b_b9fffdff,
    128'h5ae4df3e_dbd5d35e_5b4f0902_0db03eab, 128'h1e031dda_2fbe03d1_792170a0_f3009cee};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc, k, pop0;
    rst_n = 1'b0; start = 1'b0; iv_blk = '0; pt_valid = 1'b0; pt_blk = '0; ct_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    check("rst_ct_valid", 128'(ct_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ct", ct_blk, 128'(0));
    check("rst_ctr", core_blk, 128'(0));
    check("rst_pt_ready", 128'(pt_ready), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("pt_ready_after_reset", 128'(pt_ready), 128'(1));
    @(posedge clk); #1;

    // SP800-38A F.5.1 vectors
    do_start(128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff);
    check("start_loads_iv", core_blk, 128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff);
    ct_log.delete();
    send(f51_pt[0], acc0);
    for (int i = 1; i < 4; i++) send(f51_pt[i], acc);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ct_valid) break;
    end
    check("f51_latency", 128'(cyc - acc0), 128'(CORE_LAT + 1));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("f51_consecutive%0d", i), 128'(ct_valid), 128'(1));
    end
    @(negedge clk);
    check("f51_valid_drops", 128'(ct_valid), 128'(0));
    @(posedge clk); #1;
    drain("f51_drain");
    check("f51_count", 128'(ct_log.size()), 128'(4));
    for (int i = 0; i < 4; i++) check($sformatf("f51_ct%0d", i), ct_log[i], f51_ct[i]);

    // Counter wrap in word 3 only
    do_start(128'h00000001_00000002_00000003_ffffffff);
    check("wrap_ctr0", core_blk, 128'h00000001_00000002_00000003_ffffffff);
    send(rand_blk(), acc);
    check("wrap_ctr1", core_blk, 128'h00000001_00000002_00000003_00000000);
    send(rand_blk(), acc);
    check("wrap_ctr2", core_blk, 128'h00000001_00000002_00000003_00000001);
    drain("wrap_drain");

    // Start while busy is ignored
    ct_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_blk(), acc);
    repeat (2) begin @(posedge clk); #1; end
    do_start(128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_a5a5a5a5);
    check("busy_start_ctr_kept", core_blk, 128'h00000001_00000002_00000003_00000004);
    check("busy_start_busy", 128'(busy), 128'(1));
    ct_ready = 1'b1;
    send(rand_blk(), acc);
    send(rand_blk(), acc);
    check("busy_start_ctr_cont", core_blk, 128'h00000001_00000002_00000003_00000006);
    drain("busy_start_drain");

    // Backpressure: exactly DEPTH accepts with ct_ready low
    ct_ready = 1'b0;
    k = 0;
    pt_valid = 1'b1;
    for (int i = 0; i < DEPTH + 10; i++) begin
      pt_blk = {32'hb000b000, 32'h0, 32'h0, 32'(k)};
      @(negedge clk);
      if (pt_ready) k++;
      @(posedge clk); #1;
    end
    pt_valid = 1'b0;
    check("bp_accepts", 128'(k), 128'(DEPTH));
    check("bp_pt_ready_low", 128'(pt_ready), 128'(0));
    pop0 = n_pop;
    ct_ready = 1'b1;
    @(negedge clk);
    check("bp_no_comb_ready", 128'(pt_ready), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_rises", 128'(pt_ready), 128'(1));
    @(posedge clk); #1;
    drain("bp_drain");
    check("bp_pops", 128'(n_pop - pop0), 128'(DEPTH));

    // Random downstream readiness
    pop0 = n_pop;
    fork
      begin
        int a;
        for (int i = 0; i < 60; i++) send(rand_blk(), a);
      end
      begin
        for (int i = 0; i < 400; i++) begin
          ct_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    ct_ready = 1'b1;
    drain("rand_drain");
    check("rand_pops", 128'(n_pop - pop0), 128'(60));

    // Steady streaming: one block per cycle, occupancy CORE_LAT+1
    ct_ready = 1'b1;
    fork
      begin
        int a;
        for (int i = 0; i < 60; i++) send(rand_blk(), a);
      end
      begin
        repeat (CORE_LAT + 6) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk); #1;
          check("steady_ct_valid", 128'(ct_valid), 128'(1));
          check("steady_busy", 128'(busy), 128'(1));
          check("steady_occ", 128'(sb.size()), 128'(CORE_LAT + 1));
        end
      end
    join
    drain("steady_drain");

    // Reset mid-stream: 3 blocks in the CT FIFO, 5 still in the core
    ct_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(rand_blk(), acc);
    repeat (CORE_LAT - 5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pre_ct_valid", 128'(ct_valid), 128'(1));
    check("midrst_pre_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ct_valid", 128'(ct_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_ctr", core_blk, 128'(0));
    for (int i = 0; i < CORE_LAT + 2; i++) begin
      @(negedge clk);
      check("midrst_no_ct", 128'(ct_valid), 128'(0));
    end
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
